receptor_pedidos: RTL and testbench

RECEPTOR_PEDIDOS -- requirements
Module: receptor_pedidos

---
 rtl/receptor_pedidos_pkg.sv | 41 ++++
 rtl/fifo_pedidos.sv | 69 ++++++
 rtl/receptor_pedidos.sv | 126 ++++++++++++
 tb/tb_receptor_pedidos.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/receptor_pedidos_pkg.sv
// rtl/receptor_pedidos_pkg.sv - FSM encoding, byte field layout and FIFO entry type for receptor_pedidos
package receptor_pedidos_pkg;

  typedef enum logic [2:0] {
    OCIOSO     = 3'd0,
    DECODIFICA = 3'd1,
    CONTROLE   = 3'd2,
    VALIDA     = 3'd3,
    GRAVA      = 3'd4,
    DESCARTA   = 3'd5
  } estado_t;

  localparam int LARGURA_ENTRADA = 6;

  localparam int BIT_ORIGEM  = 0;
  localparam int BIT_DESTINO = 2;
  localparam int BIT_TIPO    = 4;

  localparam int BIT_INICIAR    = 0;
  localparam int BIT_RESET      = 2;
  localparam int BIT_EMERGENCIA = 4;
  localparam int BIT_CONTROLE   = 7;

  localparam logic [1:0] TIPO_NULO = 2'b00;

  typedef struct packed {
    logic [1:0] tipo;
    logic [1:0] destino;
    logic [1:0] origem;
  } entrada_t;

  // Bit 6 of a request byte carries no meaning and is dropped here.
  function automatic entrada_t extrai_entrada(input logic [7:0] b);
    entrada_t e;
    e.tipo    = b[BIT_TIPO +: 2];
    e.destino = b[BIT_DESTINO +: 2];
    e.origem  = b[BIT_ORIGEM +: 2];
    return e;
  endfunction

endpackage

// File: rtl/fifo_pedidos.sv
// rtl/fifo_pedidos.sv - circular buffer of pending requests; head read asynchronously
// Optional duplicate lookup when RECEPTOR_PEDIDOS_DEDUP_EN is defined.
module fifo_pedidos
  import receptor_pedidos_pkg::*;
#(
  parameter int PROFUNDIDADE = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            push,
  input  logic                            pop,
  input  logic                            flush,
  input  entrada_t                        dado_entrada,
  output entrada_t                        dado_saida,
  output logic [$clog2(PROFUNDIDADE):0]   ocupacao,
  output logic                            cheia
`ifdef RECEPTOR_PEDIDOS_DEDUP_EN
  ,
  input  entrada_t                        consulta,
  output logic                            duplicado
`endif
);

  localparam int AW = $clog2(PROFUNDIDADE);
  localparam logic [AW:0] CHEIO = PROFUNDIDADE[AW:0];

  entrada_t      mem [PROFUNDIDADE];
  logic [AW-1:0] ptr_escrita;
  logic [AW-1:0] ptr_leitura;
  logic          faz_push;
  logic          faz_pop;

  assign cheia    = (ocupacao == CHEIO);
  assign faz_pop  = pop && (ocupacao != '0);
  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign faz_push = push && (!cheia || faz_pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_escrita <= '0;
      ptr_leitura <= '0;
      ocupacao    <= '0;
    end else if (flush) begin
      ptr_escrita <= '0;
      ptr_leitura <= '0;
      ocupacao    <= '0;
    end else begin
      if (faz_push) ptr_escrita <= ptr_escrita + 1'b1;
      if (faz_pop)  ptr_leitura <= ptr_leitura + 1'b1;
      ocupacao <= ocupacao + {{AW{1'b0}}, faz_push} - {{AW{1'b0}}, faz_pop};
    end
  end

  always_ff @(posedge clock) begin
    if (faz_push && !flush) mem[ptr_escrita] <= dado_entrada;
  end

  assign dado_saida = (ocupacao != '0) ? mem[ptr_leitura] : '0;

`ifdef RECEPTOR_PEDIDOS_DEDUP_EN
  always_comb begin
    duplicado = 1'b0;
    for (int i = 0; i < PROFUNDIDADE; i++) begin
      if (i < int'(ocupacao) && mem[ptr_leitura + AW'(i)] == consulta) duplicado = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/receptor_pedidos.sv
// rtl/receptor_pedidos.sv - decodes serial bytes into elevator requests and control commands
// Define RECEPTOR_PEDIDOS_DEDUP_EN to reject requests already waiting in the FIFO.
module receptor_pedidos
  import receptor_pedidos_pkg::*;
#(
  parameter int PROFUNDIDADE = 4,
  parameter int ANDAR_MAX    = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          pronto,
  input  logic [7:0]                    dados_ascii,
  input  logic                          pedido_aceito,
  output logic                          pedido_valido,
  output logic [1:0]                    pedido_origem,
  output logic [1:0]                    pedido_destino,
  output logic [1:0]                    pedido_tipo,
  output logic [$clog2(PROFUNDIDADE):0] ocupacao,
  output logic                          cheia,
  output logic                          iniciar_serial,
  output logic                          reset_serial,
  output logic                          emergencia_serial,
  output logic [3:0]                    descartes,
  output logic [2:0]                    db_estado
);

  estado_t    estado;
  logic [7:0] byte_r;
  logic       pronto_ant;
  logic       borda;
  entrada_t   pedido;
  entrada_t   cabeca;
  logic       rejeita;
  logic       push;
  logic       flush;

  assign borda  = pronto && !pronto_ant;
  assign pedido = extrai_entrada(byte_r);
  assign push   = (estado == GRAVA);
  assign flush  = (estado == CONTROLE) && (byte_r[BIT_RESET] || byte_r[BIT_EMERGENCIA]);

`ifdef RECEPTOR_PEDIDOS_DEDUP_EN
  logic duplicado;
`endif

  always_comb begin
    rejeita = (pedido.tipo == TIPO_NULO)
           || (pedido.origem == pedido.destino)
           || (int'(pedido.origem) > ANDAR_MAX)
           || (int'(pedido.destino) > ANDAR_MAX)
           || emergencia_serial
           || (cheia && !pedido_aceito);
`ifdef RECEPTOR_PEDIDOS_DEDUP_EN
    if (duplicado) rejeita = 1'b1;
`endif
  end

  // Edge history restarts as "seen high": a level already high at release must drop before it counts.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado            <= OCIOSO;
      byte_r            <= '0;
      pronto_ant        <= 1'b1;
      iniciar_serial    <= 1'b0;
      reset_serial      <= 1'b0;
      emergencia_serial <= 1'b0;
      descartes         <= '0;
    end else begin
      pronto_ant     <= pronto;
      iniciar_serial <= 1'b0;
      reset_serial   <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (borda) begin
            byte_r <= dados_ascii;
            estado <= DECODIFICA;
          end
        end
        DECODIFICA: estado <= byte_r[BIT_CONTROLE] ? CONTROLE : VALIDA;
        CONTROLE: begin
          if (byte_r[BIT_EMERGENCIA]) begin
            emergencia_serial <= 1'b1;
          end else if (byte_r[BIT_INICIAR]) begin
            emergencia_serial <= 1'b0;
            iniciar_serial    <= 1'b1;
          end
          reset_serial <= byte_r[BIT_RESET];
          estado       <= OCIOSO;
        end
        VALIDA: estado <= rejeita ? DESCARTA : GRAVA;
        GRAVA:  estado <= OCIOSO;
        DESCARTA: begin
          if (descartes != 4'hF) descartes <= descartes + 4'd1;
          estado <= OCIOSO;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  fifo_pedidos #(
    .PROFUNDIDADE(PROFUNDIDADE)
  ) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .push         (push),
    .pop          (pedido_aceito),
    .flush        (flush),
    .dado_entrada (pedido),
    .dado_saida   (cabeca),
    .ocupacao     (ocupacao),
    .cheia        (cheia)
`ifdef RECEPTOR_PEDIDOS_DEDUP_EN
    ,
    .consulta     (pedido),
    .duplicado    (duplicado)
`endif
  );

  assign pedido_valido  = (ocupacao != '0);
  assign pedido_origem  = cabeca.origem;
  assign pedido_destino = cabeca.destino;
  assign pedido_tipo    = cabeca.tipo;
  assign db_estado      = estado;

endmodule

// File: tb/tb_receptor_pedidos.sv
// tb/tb_receptor_pedidos.sv - scoreboard bench for receptor_pedidos
module tb_receptor_pedidos;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       pronto = 1'b0;
  logic [7:0] dados_ascii = 8'h00;
  logic       pedido_aceito = 1'b0;
  logic       pedido_valido;
  logic [1:0] pedido_origem;
  logic [1:0] pedido_destino;
  logic [1:0] pedido_tipo;
  logic [2:0] ocupacao;
  logic       cheia;
  logic       iniciar_serial;
  logic       reset_serial;
  logic       emergencia_serial;
  logic [3:0] descartes;
  logic [2:0] db_estado;

  int         testes = 0;
  int         falhas = 0;
  int         n_iniciar = 0;
  int         n_reset_serial = 0;
  int         base;
  logic [5:0] esperado[$];

  always #5 clock = ~clock;

  receptor_pedidos #(
    .PROFUNDIDADE(4),
    .ANDAR_MAX(3)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .pronto            (pronto),
    .dados_ascii       (dados_ascii),
    .pedido_aceito     (pedido_aceito),
    .pedido_valido     (pedido_valido),
    .pedido_origem     (pedido_origem),
    .pedido_destino    (pedido_destino),
    .pedido_tipo       (pedido_tipo),
    .ocupacao          (ocupacao),
    .cheia             (cheia),
    .iniciar_serial    (iniciar_serial),
    .reset_serial      (reset_serial),
    .emergencia_serial (emergencia_serial),
    .descartes         (descartes),
    .db_estado         (db_estado)
  );

  task automatic verifica(input string nome, input int atual, input int exigido);
    testes++;
    if (atual != exigido) begin
      falhas++;
      $display("FAIL %s: got %0d, expected %0d", nome, atual, exigido);
    end
  endtask

  // Monitor: every pop the DUT performs is checked against the oldest expected entry.
  initial begin
    logic [5:0] e;
    forever begin
      @(negedge clock);
      if (pedido_valido && pedido_aceito) begin
        if (esperado.size() == 0) begin
          testes++;
          falhas++;
          $display("FAIL pop_inesperado: got 0x%02h, expected no entry", {pedido_tipo, pedido_destino, pedido_origem});
        end else begin
          e = esperado.pop_front();
          verifica("cabeca_pop", int'({pedido_tipo, pedido_destino, pedido_origem}), int'(e));
        end
      end
      if (iniciar_serial) n_iniciar++;
      if (reset_serial) n_reset_serial++;
    end
  end

  task automatic aplica_reset();
    reset = 1'b0;
    pronto = 1'b0;
    pedido_aceito = 1'b0;
    esperado.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // One byte every 7 cycles; ciclo_aceito picks the cycle (0 = edge) in which the consumer pops.
  task automatic envia(input logic [7:0] b, input int ciclo_aceito, input bit guarda);
    if (guarda) esperado.push_back(b[5:0]);
    dados_ascii = b;
    for (int c = 0; c < 7; c++) begin
      pronto = (c == 0);
      pedido_aceito = (c == ciclo_aceito);
      @(posedge clock);
      #1;
    end
    pedido_aceito = 1'b0;
  endtask

  task automatic drena(input int n);
    pedido_aceito = 1'b1;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
    pedido_aceito = 1'b0;
  endtask

  task automatic amostra();
    @(negedge clock);
  endtask

  task automatic realinha();
    @(posedge clock);
    #1;
  endtask

  initial begin
    aplica_reset();
    amostra();
    verifica("reset_valido", int'(pedido_valido), 0);
    verifica("reset_ocupacao", int'(ocupacao), 0);
    verifica("reset_descartes", int'(descartes), 0);
    verifica("reset_estado", int'(db_estado), 0);
    verifica("reset_cabeca", int'({pedido_tipo, pedido_destino, pedido_origem}), 0);
    realinha();

    // Valid request 0x19 with latency check.
    esperado.push_back(6'h19);
    dados_ascii = 8'h19;
    for (int c = 0; c <= 4; c++) begin
      pronto = (c == 0);
      @(negedge clock);
      if (c == 3) verifica("latencia_ciclo3", int'(pedido_valido), 0);
      if (c == 4) verifica("latencia_ciclo4", int'(pedido_valido), 1);
      @(posedge clock);
      #1;
    end
    pronto = 1'b0;
    amostra();
    verifica("origem_0x19", int'(pedido_origem), 1);
    verifica("destino_0x19", int'(pedido_destino), 2);
    verifica("tipo_0x19", int'(pedido_tipo), 1);
    realinha();
    drena(1);

    // Invalid requests, then saturation of the discard counter.
    envia(8'h05, -1, 1'b0);
    envia(8'h0E, -1, 1'b0);
    amostra();
    verifica("descartes_invalidos", int'(descartes), 2);
    verifica("valido_apos_invalidos", int'(pedido_valido), 0);
    realinha();
    for (int i = 0; i < 14; i++) envia(8'h00, -1, 1'b0);
    amostra();
    verifica("descartes_saturado", int'(descartes), 15);
    realinha();

    // Overflow with no pops.
    aplica_reset();
    envia(8'h19, -1, 1'b1);
    envia(8'h1B, -1, 1'b1);
    envia(8'h24, -1, 1'b1);
    envia(8'h36, -1, 1'b1);
    envia(8'h1C, -1, 1'b0);
    amostra();
    verifica("cheia_overflow", int'(cheia), 1);
    verifica("ocupacao_overflow", int'(ocupacao), 4);
    verifica("descartes_overflow", int'(descartes), 1);
    verifica("cabeca_overflow", int'({pedido_tipo, pedido_destino, pedido_origem}), 'h19);
    realinha();

    // Full FIFO with the consumer popping in VALIDA: the new request still lands.
    envia(8'h2D, 2, 1'b1);
    amostra();
    verifica("ocupacao_pop_valida", int'(ocupacao), 4);
    verifica("descartes_pop_valida", int'(descartes), 1);
    realinha();
    drena(1);
    // Push and pop in the same GRAVA cycle.
    envia(8'h39, 3, 1'b1);
    amostra();
    verifica("ocupacao_push_pop", int'(ocupacao), 3);
    verifica("descartes_push_pop", int'(descartes), 1);
    realinha();
    drena(3);
    drena(1);
    amostra();
    verifica("ocupacao_drenada", int'(ocupacao), 0);
    verifica("fila_esperada_vazia", esperado.size(), 0);
    realinha();

    // Emergency flush, rejection under emergency, clear via 0x81.
    aplica_reset();
    envia(8'h19, -1, 1'b1);
    envia(8'h1B, -1, 1'b1);
    envia(8'h24, -1, 1'b1);
    envia(8'h90, -1, 1'b0);
    esperado.delete();
    amostra();
    verifica("emergencia_ativa", int'(emergencia_serial), 1);
    verifica("ocupacao_emergencia", int'(ocupacao), 0);
    realinha();
    envia(8'h36, -1, 1'b0);
    amostra();
    verifica("descartes_emergencia", int'(descartes), 1);
    verifica("ocupacao_emergencia2", int'(ocupacao), 0);
    realinha();
    base = n_iniciar;
    envia(8'h81, -1, 1'b0);
    amostra();
    verifica("pulsos_iniciar", n_iniciar - base, 1);
    verifica("emergencia_limpa", int'(emergencia_serial), 0);
    realinha();
    base = n_iniciar;
    envia(8'h91, -1, 1'b0);
    amostra();
    verifica("prioridade_emergencia", int'(emergencia_serial), 1);
    verifica("iniciar_suprimido", n_iniciar - base, 0);
    realinha();
    envia(8'h81, -1, 1'b0);
    envia(8'h19, -1, 1'b1);
    base = n_reset_serial;
    envia(8'h84, -1, 1'b0);
    esperado.delete();
    amostra();
    verifica("pulsos_reset_serial", n_reset_serial - base, 1);
    verifica("ocupacao_reset_serial", int'(ocupacao), 0);
    realinha();

    // Reset during VALIDA, with pronto held high across release.
    aplica_reset();
    dados_ascii = 8'h19;
    pronto = 1'b1;
    realinha();
    pronto = 1'b0;
    realinha();
    amostra();
    verifica("estado_valida", int'(db_estado), 3);
    reset = 1'b0;
    pronto = 1'b1;
    #1;
    verifica("estado_reset_assinc", int'(db_estado), 0);
    realinha();
    reset = 1'b1;
    repeat (5) realinha();
    amostra();
    verifica("estado_pos_reset", int'(db_estado), 0);
    verifica("ocupacao_pos_reset", int'(ocupacao), 0);
    verifica("valido_pos_reset", int'(pedido_valido), 0);
    verifica("descartes_pos_reset", int'(descartes), 0);
    realinha();
    pronto = 1'b0;
    realinha();

    // Duplicate requests.
    envia(8'h19, -1, 1'b1);
`ifdef RECEPTOR_PEDIDOS_DEDUP_EN
    envia(8'h19, -1, 1'b0);
    amostra();
    verifica("ocupacao_duplicado", int'(ocupacao), 1);
    verifica("descartes_duplicado", int'(descartes), 1);
`else
    envia(8'h19, -1, 1'b1);
    amostra();
    verifica("ocupacao_duplicado", int'(ocupacao), 2);
    verifica("descartes_duplicado", int'(descartes), 0);
`endif
    realinha();
    drena(2);
    amostra();
    verifica("fila_final_vazia", esperado.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
